// File: rtl/writeback_pkg.sv
// y86_pkg: shared Y-86 constants, status codes and write-back state type
package y86_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 15;
  localparam int CNT_W = 32;
  localparam logic [3:0] HALT = 4'h0;
  localparam logic [3:0] NOP = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ = 4'h6;
  localparam logic [3:0] JXX = 4'h7;
  localparam logic [3:0] CALL = 4'h8;
  localparam logic [3:0] RET = 4'h9;
  localparam logic [3:0] PUSHQ = 4'hA;
  localparam logic [3:0] POPQ = 4'hB;
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;
  localparam logic [3:0] RSP = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;
  typedef enum logic {RUN, HALTED} state_t;
endpackage

// File: rtl/writeback_if.sv
// writeback_if: retire bus, operand read ports and status outputs of the write-back stage
interface writeback_if;
  logic instr_valid;
  logic [3:0] icode;
  logic [3:0] ifun;
  logic cnd;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [y86_pkg::XLEN-1:0] valE;
  logic [y86_pkg::XLEN-1:0] valM;
  logic [2:0] stat_in;
  logic [3:0] srcA;
  logic [3:0] srcB;
  logic [y86_pkg::XLEN-1:0] rdA;
  logic [y86_pkg::XLEN-1:0] rdB;
  logic [2:0] stat;
  logic halted;
  logic [y86_pkg::CNT_W-1:0] retired;
  modport master(output instr_valid, icode, ifun, cnd, ra, rb, valE, valM, stat_in, srcA, srcB,
                 input rdA, rdB, stat, halted, retired);
  modport slave(input instr_valid, icode, ifun, cnd, ra, rb, valE, valM, stat_in, srcA, srcB,
                output rdA, rdB, stat, halted, retired);
endinterface

// File: rtl/writeback_regfile.sv
// regfile: 15-entry register array, two combinational reads, two writes with port M winning
module regfile
  import y86_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we_e,
  input  logic [3:0] dst_e,
  input  logic [XLEN-1:0] val_e,
  input  logic we_m,
  input  logic [3:0] dst_m,
  input  logic [XLEN-1:0] val_m,
  input  logic [3:0] src_a,
  input  logic [3:0] src_b,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b
);
  logic [XLEN-1:0] regs [NREG];
  // reset loads each register with its own index; index F never matches an entry
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < NREG; i++) regs[i] <= XLEN'(i);
    else
      for (int i = 0; i < NREG; i++)
        if (we_m && dst_m == 4'(i)) regs[i] <= val_m;
        else if (we_e && dst_e == 4'(i)) regs[i] <= val_e;
  assign rd_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign rd_b = (src_b == RNONE) ? '0 : regs[src_b];
endmodule

// File: rtl/writeback.sv
// writeback: SEQ write-back stage with destination decode, status FSM and retire counter
module writeback
  import y86_pkg::*;
(
  input  logic clk,
  input  logic reset,
  writeback_if.slave bus
);
  state_t state, state_next;
  logic [3:0] dst_e, dst_m;
  logic [2:0] stat_q;
  logic [CNT_W-1:0] retired_q;
  logic commit, ok, wr;
  assign commit = bus.instr_valid && state == RUN;
  assign ok = bus.stat_in == AOK;
  assign wr = commit && ok && bus.icode != HALT;
  // destination registers implied by the retiring instruction
  always_comb begin
    dst_e = (bus.icode == RRMOVQ) ? ((bus.ifun == 4'h0 || bus.cnd) ? bus.rb : RNONE) :
            (bus.icode == IRMOVQ || bus.icode == OPQ) ? bus.rb :
            (bus.icode inside {CALL, RET, PUSHQ, POPQ}) ? RSP : RNONE;
    dst_m = (bus.icode == MRMOVQ || bus.icode == POPQ) ? bus.ra : RNONE;
  end
  regfile u_rf (
    .clk(clk), .rst(reset),
    .we_e(wr), .dst_e(dst_e), .val_e(bus.valE),
    .we_m(wr), .dst_m(dst_m), .val_m(bus.valM),
    .src_a(bus.srcA), .src_b(bus.srcB), .rd_a(bus.rdA), .rd_b(bus.rdB)
  );
  // status state register
  always_ff @(posedge clk)
    if (reset) state <= RUN;
    else state <= state_next;
  // a halt or a faulting status ends the run until reset
  always_comb state_next = (commit && (!ok || bus.icode == HALT)) ? HALTED : state;
  // status code and retired count; faults retire nothing
  always_ff @(posedge clk)
    if (reset) begin
      stat_q <= AOK;
      retired_q <= '0;
    end else if (commit) begin
      stat_q <= !ok ? bus.stat_in : (bus.icode == HALT) ? HLT : stat_q;
      retired_q <= ok ? retired_q + 1'b1 : retired_q;
    end
  // status outputs
  always_comb begin
    bus.halted = state == HALTED;
    bus.stat = stat_q;
    bus.retired = retired_q;
  end
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed plus randomized checks of writeback against a behavioural model
module tb_writeback;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int failures = 0;
  writeback_if bus();
  writeback dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [63:0] mreg [15];
  logic [2:0] mstat;
  logic mhalt;
  logic [31:0] mret;

  function automatic logic [63:0] rexp(input logic [3:0] i);
    return (i == 4'hF) ? 64'd0 : mreg[i];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic dests(input logic [3:0] ic, input logic [3:0] fn, input logic c,
                       input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] de, output logic [3:0] dm);
    de = 4'hF;
    dm = 4'hF;
    case (ic)
      4'h2: if (fn == 0 || c) de = b;
      4'h3, 4'h6: de = b;
      4'h5: dm = a;
      4'h8, 4'h9, 4'hA: de = 4'h4;
      4'hB: begin de = 4'h4; dm = a; end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_stat"}, 64'(bus.stat), 64'(mstat));
    chk({tag, "_halted"}, 64'(bus.halted), 64'(mhalt));
    chk({tag, "_retired"}, 64'(bus.retired), 64'(mret));
    for (int i = 0; i < 16; i++) begin
      bus.srcA = 4'(i);
      bus.srcB = 4'(15 - i);
      #1;
      chk($sformatf("%s_rdA%0d", tag, i), bus.rdA, rexp(4'(i)));
      chk($sformatf("%s_rdB%0d", tag, 15 - i), bus.rdB, rexp(4'(15 - i)));
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [3:0] ic, input logic [3:0] fn, input logic c,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [63:0] e, input logic [63:0] m, input logic [2:0] si);
    logic [3:0] de, dm;
    @(negedge clk);
    reset = r;
    bus.instr_valid = v;
    bus.icode = ic;
    bus.ifun = fn;
    bus.cnd = c;
    bus.ra = a;
    bus.rb = b;
    bus.valE = e;
    bus.valM = m;
    bus.stat_in = si;
    bus.srcA = b;
    bus.srcB = a;
    #1;
    if (!r) begin
      chk({tag, "_prewrite_a"}, bus.rdA, rexp(b));
      chk({tag, "_prewrite_b"}, bus.rdB, rexp(a));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 15; i++) mreg[i] = 64'(i);
      mstat = 3'd1;
      mhalt = 0;
      mret = 0;
    end else if (v && !mhalt) begin
      if (si != 3'd1) begin
        mhalt = 1;
        mstat = si;
      end else begin
        mret = mret + 1;
        if (ic == 4'h0) begin
          mhalt = 1;
          mstat = 3'd2;
        end else begin
          dests(ic, fn, c, a, b, de, dm);
          if (de != 4'hF) mreg[de] = e;
          if (dm != 4'hF) mreg[dm] = m;
        end
      end
    end
    #1;
    reset = 0;
    bus.instr_valid = 0;
    check_all(tag);
  endtask

  initial begin
    logic r, v, c;
    logic [3:0] ic, fn, a, b;
    logic [2:0] si;
    bus.instr_valid = 0;
    bus.icode = 0;
    bus.ifun = 0;
    bus.cnd = 0;
    bus.ra = 0;
    bus.rb = 0;
    bus.valE = 0;
    bus.valM = 0;
    bus.stat_in = 1;
    bus.srcA = 0;
    bus.srcB = 4'hF;
    step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("irmovq", 0, 1, 4'h3, 0, 0, 4'hF, 4'h2, 64'hDEAD, 0, 1);
    step("cmov_nc", 0, 1, 4'h2, 4'h3, 0, 4'h1, 4'h5, 64'd7, 0, 1);
    step("cmov_c", 0, 1, 4'h2, 4'h3, 1, 4'h1, 4'h5, 64'd7, 0, 1);
    step("rrmov", 0, 1, 4'h2, 4'h0, 0, 4'h5, 4'h7, 64'h77, 0, 1);
    step("idle", 0, 0, 4'h3, 0, 0, 4'hF, 4'h8, 64'h55, 0, 1);
    step("mrmov", 0, 1, 4'h5, 0, 0, 4'h9, 4'hF, 64'h11, 64'h99, 1);
    step("popq_rsp", 0, 1, 4'hB, 0, 0, 4'h4, 4'hF, 64'h100, 64'h200, 1);
    step("pushq", 0, 1, 4'hA, 0, 0, 4'h3, 4'hF, 64'h1F8, 64'h0, 1);
    step("halt", 0, 1, 4'h0, 0, 0, 4'hF, 4'h1, 64'd5, 0, 1);
    step("after_halt", 0, 1, 4'h3, 0, 0, 4'hF, 4'h1, 64'd9, 0, 1);
    step("reset2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("adr", 0, 1, 4'h6, 0, 0, 4'h2, 4'h6, 64'hBAD, 0, 3);
    step("after_adr", 0, 1, 4'h6, 0, 0, 4'h2, 4'h6, 64'hBAD, 0, 1);
    step("reset_dom", 1, 1, 4'h3, 0, 0, 4'hF, 4'h6, 64'h66, 0, 1);
    step("ins", 0, 1, 4'hB, 0, 0, 4'h4, 4'hF, 64'h1, 64'h2, 4);
    step("reset3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 14) == 0;
      v = $urandom_range(0, 7) != 0;
      ic = ($urandom_range(0, 39) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      fn = 4'($urandom_range(0, 6));
      c = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      si = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      step("rand", r, v, ic, fn, c, a, b, {$urandom, $urandom}, {$urandom, $urandom}, si);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- SEQ write-back stage and owner of the Y-86 register file (15 x 64-bit, rax..r14).
- Each clock it retires one instruction:
  - commits valE to dstE and valM to dstM;
  - tracks processor status in a RUN/HALTED state machine;
  - counts retired instructions.
- Exposes two read ports through which the decode stage fetches operands.

Parameters:
- XLEN, 64, register/data width.
- NREG, 15, architectural registers; index 4'hF means "no register".
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  an instruction retires this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- cnd  in  1  condition outcome from execute (used by cmovXX).
- ra  in  4  rA field.
- rb  in  4  rB field.
- valE  in  XLEN  ALU result.
- valM  in  XLEN  memory read data.
- stat_in  in  3  status from fetch/memory: AOK=1, HLT=2, ADR=3, INS=4.
- srcA  in  4  read port A index.
- srcB  in  4  read port B index.
- rdA  out  XLEN  register[srcA]; 0 when srcA=4'hF.
- rdB  out  XLEN  register[srcB]; 0 when srcB=4'hF.
- stat  out  3  current processor status.
- halted  out  1  high in HALTED state.
- retired  out  CNT_W  count of committed instructions.

Behaviour:
- Reset (synchronous, active-high), applied at a rising clk edge while reset=1:
  - register[i] = i for i = 0..14;
  - state = RUN, stat = AOK, halted = 0, retired = 0.
  - Reset dominates every other input on the same edge.
  - Reset asserted mid-run or while HALTED is a full reinitialisation.
- Destination decode (combinational):
  - icode 2 (rrmovq/cmovXX): dstE = rb if (ifun==0 or cnd), else F.
  - icode 3 (irmovq), icode 6 (OPq): dstE = rb.
  - icode 5 (mrmovq): dstM = ra.
  - icode 8 (call), 9 (ret), A (pushq): dstE = 4 (rsp).
  - icode B (popq): dstE = 4, dstM = ra.
  - All other icodes: dstE = dstM = F.
- Commit, on a rising edge with instr_valid=1 and state=RUN:
  - If stat_in == AOK and icode != 0: write valE to dstE and valM to dstM (index F ignored).
  - If dstE == dstM (popq %rsp), the valM write wins.
  - retired increments by 1, wrapping modulo 2^CNT_W.
  - If icode == 0 (halt): no register writes; stat <= HLT; state -> HALTED; retired increments.
  - If stat_in != AOK: no register writes; stat <= stat_in; state -> HALTED; retired unchanged.
- instr_valid=0: no writes, no counter change, state unchanged.
- HALTED: absorbing until reset; all writes and counting suppressed; halted=1 and stat is held.
- Read ports:
  - Purely combinational from the current array.
  - No write-to-read bypass: a read in the same cycle as a write returns the old value; the new value is visible after the edge.
- One write per port per cycle; a write never affects a register other than dstE/dstM.

Decomposition:
- Package y86_pkg holds:
  - icode constants (HALT, NOP, RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ);
  - stat codes (AOK, HLT, ADR, INS);
  - RSP=4, RNONE=4'hF;
  - the state enum RUN/HALTED.
- Sub-module regfile: 15x64 array with 2 combinational read ports and 2 synchronous write ports (port M has priority). It handles the reset initialisation.
- Destination decode, status FSM and counter stay in writeback.

Test Plan:
- Reset, then read srcA=3, srcB=F -> rdA=3, rdB=0, stat=1, retired=0.
- irmovq (icode 3, rb=2, valE=0xDEAD) -> next cycle rdA(src 2)=0xDEAD; retired=1.
- cmovXX:
  - icode 2, ifun 3, cnd=0, rb=5, valE=7 -> r5 stays 5;
  - same with cnd=1 -> r5=7.
- popq (icode B) with ra=4, valE=0x100, valM=0x200 -> r4=0x200 after the edge.
- halt (icode 0):
  - -> stat=2, halted=1, retired increments;
  - subsequent irmovq rb=1 valE=9 -> r1 stays 1, retired unchanged.
- stat_in=3 (ADR) with OPq rb=6 -> r6 unchanged, stat=3, halted=1.
- Reset in the same cycle -> r6=6, stat=1, halted=0.
